// File: rtl/seq_detector_param.sv
// Parametrised Moore sequence detector with a run-time loadable pattern,
// optional overlapping matches and a saturating match counter.
module seq_detector_param #(
    parameter int           N       = 4,
    parameter int           CNT_W   = 8,
    parameter logic [N-1:0] PAT_RST = '0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     x,
    input  logic                     EN,
    input  logic                     OVL,
    input  logic                     LOAD,
    input  logic [N-1:0]             PAT,
    output logic                     F,
    output logic [$clog2(N+1)-1:0]   S,
    output logic [CNT_W-1:0]         CNT
);

    localparam int             SW     = $clog2(N+1);
    localparam logic [SW-1:0]  S_FULL = SW'(N);

    logic [N-1:0]     p_q, p_d;
    // Only the N-1 most recent old bits can ever join x in a length-N match.
    logic [N-2:0]     hist_q, hist_d;
    logic [SW-1:0]    hl_q, hl_d;
    logic [SW-1:0]    s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             restart;
    logic [N-1:0]     win;
    logic [SW-1:0]    hl_c;
    logic [SW-1:0]    s_c;
    logic             hit;

    // Outcome of consuming x: every prefix length is tested in parallel and
    // the longest one that fits the valid history wins.
    always_comb begin
        restart = !OVL && (s_q == S_FULL);
        win     = {hist_q, x};
        if (restart) begin
            hl_c = SW'(1);
        end else if (hl_q == S_FULL) begin
            hl_c = S_FULL;
        end else begin
            hl_c = hl_q + SW'(1);
        end
        s_c = '0;
        hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
            hit = (SW'(k) <= hl_c);
            for (int j = 0; j < k; j++) begin
                if (win[j] != p_q[N-k+j]) begin
                    hit = 1'b0;
                end
            end
            if (hit) begin
                s_c = SW'(k);
            end
        end
    end

    always_comb begin
        p_d    = p_q;
        hist_d = hist_q;
        hl_d   = hl_q;
        s_d    = s_q;
        cnt_d  = cnt_q;
        if (LOAD) begin
            p_d  = PAT;
            s_d  = '0;
            hl_d = '0;
        end else if (EN) begin
            hist_d = win[N-2:0];
            hl_d   = hl_c;
            s_d    = s_c;
            if ((s_c == S_FULL) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            p_q    <= PAT_RST;
            hist_q <= '0;
            hl_q   <= '0;
            s_q    <= '0;
            cnt_q  <= '0;
        end else begin
            p_q    <= p_d;
            hist_q <= hist_d;
            hl_q   <= hl_d;
            s_q    <= s_d;
            cnt_q  <= cnt_d;
        end
    end

    assign S   = s_q;
    assign F   = (s_q == S_FULL);
    assign CNT = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param; a stream-level model
// predicts S/F/CNT for an 8-bit and a 2-bit counter instance.
module tb_seq_detector_param;

  localparam int N  = 4;
  localparam int SW = $clog2(N+1);
  localparam int W  = SW + 1 + 8 + 2;

  logic          CLK   = 1'b0;
  logic          RESET = 1'b1;
  logic          x     = 1'b0;
  logic          EN    = 1'b0;
  logic          OVL   = 1'b0;
  logic          LOAD  = 1'b0;
  logic [N-1:0]  PAT   = '0;

  logic          f_o, f2_o;
  logic [SW-1:0] s_o, s2_o;
  logic [7:0]    cnt_o;
  logic [1:0]    cnt2_o;

  logic [W-1:0]  exp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  // reference model: the consumed stream since the last restart
  logic [N-1:0]  m_pat;
  bit            m_stream[$];
  int            m_s, m_cnt, m_cnt2;

  seq_detector_param #(.N(N), .CNT_W(8), .PAT_RST(4'b0000)) dut (
    .CLK(CLK), .RESET(RESET), .x(x), .EN(EN), .OVL(OVL), .LOAD(LOAD),
    .PAT(PAT), .F(f_o), .S(s_o), .CNT(cnt_o)
  );

  seq_detector_param #(.N(N), .CNT_W(2), .PAT_RST(4'b0000)) dut_sat (
    .CLK(CLK), .RESET(RESET), .x(x), .EN(EN), .OVL(OVL), .LOAD(LOAD),
    .PAT(PAT), .F(f2_o), .S(s2_o), .CNT(cnt2_o)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic void model_reset();
    m_pat = 4'b0000;
    m_stream.delete();
    m_s    = 0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endfunction

  function automatic void model_step(input logic xi, input logic en, input logic ovl,
                                     input logic load, input logic [N-1:0] pat);
    int best, len;
    bit ok;
    if (load) begin
      m_pat = pat;
      m_stream.delete();
      m_s = 0;
    end else if (en) begin
      if (!ovl && m_s == N) m_stream.delete();
      m_stream.push_back(xi);
      if (m_stream.size() > N) void'(m_stream.pop_front());
      len  = m_stream.size();
      best = 0;
      for (int k = 1; k <= N; k++) begin
        if (k <= len) begin
          ok = 1;
          for (int i = 0; i < k; i++)
            if (m_stream[len-k+i] != m_pat[N-1-i]) ok = 0;
          if (ok) best = k;
        end
      end
      m_s = best;
      if (m_s == N) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  endfunction

  // driver tasks
  task automatic step(input logic xi, input logic en, input logic ovl,
                      input logic load, input logic [N-1:0] pat);
    logic [W-1:0] e;
    @(negedge CLK);
    x = xi; EN = en; OVL = ovl; LOAD = load; PAT = pat;
    model_step(xi, en, ovl, load, pat);
    e = {SW'(m_s), (m_s == N), 8'(m_cnt), 2'(m_cnt2)};
    exp_q.push_back(e);
  endtask

  task automatic run_bits(input logic [15:0] bits, input int len, input logic ovl);
    for (int i = 0; i < len; i++) step(bits[len-1-i], 1'b1, ovl, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    EN = 1'b0; LOAD = 1'b0;
    #1 RESET = 1'b1;
    #1;
    check("async_reset_S", int'(s_o), 0);
    check("async_reset_F", int'(f_o), 0);
    check("async_reset_CNT", int'(cnt_o), 0);
    check("async_reset_CNT2", int'(cnt2_o), 0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("S", int'(s_o), int'(e[W-1 -: SW]));
        check("F", int'(f_o), int'(e[10]));
        check("CNT", int'(cnt_o), int'(e[9:2]));
        check("S_sat_inst", int'(s2_o), int'(e[W-1 -: SW]));
        check("CNT_sat", int'(cnt2_o), int'(e[1:0]));
      end
    end
  end

  initial begin
    int r;
    model_reset();
    repeat (2) @(negedge CLK);
    check("reset_S", int'(s_o), 0);
    check("reset_F", int'(f_o), 0);
    check("reset_CNT", int'(cnt_o), 0);
    RESET = 1'b0;

    // pattern register comes out of reset as PAT_RST (0000)
    run_bits(16'b0000_0, 5, 1'b1);

    // overlapping vs non-overlapping on 1011
    do_reset();
    step(0, 0, 1, 1, 4'b1011);
    run_bits(16'b1011011, 7, 1'b1);
    do_reset();
    step(0, 0, 0, 1, 4'b1011);
    run_bits(16'b1011011, 7, 1'b0);

    // all-ones self-overlap
    do_reset();
    step(0, 0, 1, 1, 4'b1111);
    run_bits(16'b111111, 6, 1'b1);
    do_reset();
    step(0, 0, 0, 1, 4'b1111);
    run_bits(16'b111111, 6, 1'b0);

    // EN=0 holds state while x toggles
    do_reset();
    step(0, 0, 1, 1, 4'b1011);
    run_bits(16'b101, 3, 1'b1);
    for (int i = 0; i < 3; i++) step(i[0], 1'b0, 1'b1, 1'b0, '0);
    step(1, 1, 1, 0, '0);

    // LOAD mid-stream restarts without touching CNT
    step(0, 0, 1, 1, 4'b1011);
    run_bits(16'b101, 3, 1'b1);
    step(1, 1, 1, 1, 4'b0110);
    run_bits(16'b0110, 4, 1'b1);

    // asynchronous reset mid-match, then PAT_RST is active again
    step(0, 0, 1, 1, 4'b1011);
    run_bits(16'b101, 3, 1'b1);
    do_reset();
    run_bits(16'b0000, 4, 1'b0);

    // randomised traffic, with enough matches to saturate the 2-bit counter
    step(0, 0, 1, 1, 4'b1011);
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
             (r < 6), 4'($urandom_range(0, 15)));
      end
    end

    repeat (3) @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
